// File: rtl/seg_scan_ctrl_if.sv
// Write port and display-drive signals of the four-digit 7-segment controller.
// The CPU I/O stage (or a bench) is the master; the controller is the slave.
interface seg_scan_ctrl_if;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        wr_hex;
   logic        blank_lz;
   logic        busy;
   logic        ovf;
   logic [3:0]  an;
   logic [3:0]  digit_bcd;

   modport master (
      output wr_en, wr_data, wr_hex, blank_lz,
      input  busy, ovf, an, digit_bcd
   );

   modport slave (
      input  wr_en, wr_data, wr_hex, blank_lz,
      output busy, ovf, an, digit_bcd
   );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment controller: binary-to-BCD shift-add-3
// conversion (or raw hex nibbles) committed atomically, then scanned one digit per slot.
module seg_scan_ctrl #(
   parameter int SCAN_DIV = 50000
) (
   input  logic          clk,
   input  logic          rst_n,
   seg_scan_ctrl_if.slave bus
);

   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [15:0]   acc;
   logic [14:0]   acc_adj;
   logic [13:0]   sreg;
   logic [3:0]    cnt;
   logic          sat;
   logic          blz_r;
   logic [15:0]   disp;
   logic [15:0]   disp_nxt;
   logic          ovf_r;
   logic [PW-1:0] presc;
   logic [1:0]    idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.wr_en) state_nxt = bus.wr_hex ? COMMIT : SHIFT;
         SHIFT:   if (cnt == 4'd1) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The thousands nibble is at most 4 before any shift when the input is
   // capped at 9999, so only the lower three nibbles ever need the +3 fix.
   always_comb begin
      acc_adj = acc[14:0];
      for (int k = 0; k < 3; k++) begin
         if (acc[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
      end
   end

   always_comb begin
      disp_nxt = acc;
      if (blz_r && acc[15:12] == 4'd0) begin
         disp_nxt[15:12] = 4'hF;
         if (acc[11:8] == 4'd0) begin
            disp_nxt[11:8] = 4'hF;
            if (acc[7:4] == 4'd0) disp_nxt[7:4] = 4'hF;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= 16'd0;
         sreg  <= 14'd0;
         cnt   <= 4'd0;
         sat   <= 1'b0;
         blz_r <= 1'b0;
         disp  <= 16'hFFFF;
         ovf_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.wr_en) begin
                  blz_r <= bus.blank_lz;
                  if (bus.wr_hex) begin
                     acc <= bus.wr_data;
                     sat <= 1'b0;
                  end else begin
                     acc <= 16'd0;
                     cnt <= 4'd14;
                     if (bus.wr_data > 16'd9999) begin
                        sreg <= 14'd9999;
                        sat  <= 1'b1;
                     end else begin
                        sreg <= bus.wr_data[13:0];
                        sat  <= 1'b0;
                     end
                  end
               end
            end
            SHIFT: begin
               acc  <= {acc_adj, sreg[13]};
               sreg <= {sreg[12:0], 1'b0};
               cnt  <= cnt - 4'd1;
            end
            COMMIT: begin
               disp  <= disp_nxt;
               ovf_r <= sat;
            end
            default: ;
         endcase
      end
   end

   // Scan timing runs freely and never looks at the conversion state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
         idx   <= 2'd0;
      end else if (presc == PW'(SCAN_DIV - 1)) begin
         presc <= '0;
         idx   <= idx + 2'd1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   always_comb begin
      bus.digit_bcd = disp[3:0];
      case (idx)
         2'd0:    bus.digit_bcd = disp[3:0];
         2'd1:    bus.digit_bcd = disp[7:4];
         2'd2:    bus.digit_bcd = disp[11:8];
         default: bus.digit_bcd = disp[15:12];
      endcase
   end

   assign bus.an   = ~(4'b0001 << idx);
   assign bus.busy = (state != IDLE);
   assign bus.ovf  = ovf_r;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Display controller for the board's four-digit multiplexed 7-segment display. It accepts a value written by the CPU's memory-mapped I/O stage and, in decimal mode, converts it from binary to four BCD digits with a sequential shift-add-3 converter. It then time-multiplexes the digits: each scan slot drives one 4-bit BCD nibble to the external BCD-to-7-segment decoder and one active-low anode. Nibble 4'hF is the blank code, which the decoder renders as all segments off.

## Interface
- SCAN_DIV, 50000: clk cycles each digit is lit; minimum 2.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe, one cycle; accepted only when busy=0.
- wr_data  in  16  value; decimal mode uses the full unsigned value, hex mode uses nibbles [15:12]..[3:0] as digits 3..0.
- wr_hex  in  1  sampled with wr_en; 1 = raw nibble mode, 0 = decimal conversion.
- blank_lz  in  1  sampled with wr_en; 1 = blank leading zeros.
- busy  out  1  conversion in progress; writes are ignored while high.
- ovf  out  1  displayed value was saturated to 9999.
- an  out  4  anode select, active-low, one-hot-zero; bit i = digit i (0 = rightmost).
- digit_bcd  out  4  nibble for the lit digit, to the decoder input.

## Operation
- The FSM has three states: IDLE, SHIFT, COMMIT.
- IDLE: wr_en=1 is accepted. The block latches wr_hex and blank_lz.
  - Decimal mode: if wr_data > 9999, the shift register loads 14'd9999 and sat=1; otherwise it loads wr_data[13:0] and sat=0. The BCD accumulator is cleared, the bit counter is set to 14, and the FSM goes to SHIFT.
  - Hex mode: the accumulator loads wr_data, sat=0, and the FSM goes directly to COMMIT.
- SHIFT: each cycle, every accumulator nibble ≥5 gets +3. The accumulator then shifts left by one, taking in the shift register MSB, and the shift register shifts left. The counter decrements. The FSM leaves for COMMIT after 14 iterations.
- COMMIT: the accumulator is copied to the four display registers disp[3:0] atomically, ovf<=sat, and the FSM returns to IDLE.
- Leading-zero blanking, applied in COMMIT when blank_lz=1: from digit 3 downward, each zero nibble becomes 4'hF until the first non-zero nibble. Digit 0 is never blanked, so a value of 0 shows "0".
- busy=1 in SHIFT and COMMIT. A wr_en while busy=1 is dropped with no side effects; the block does not queue it.
- Scanner, independent of the FSM:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index idx advances 0→1→2→3→0.
  - an = ~(4'b0001<<idx) and digit_bcd = disp[idx]; both are combinational from registers.
- Display registers change only in COMMIT, so the scan never shows a partial conversion.

## Timing
- Reset values:
  - state IDLE, busy=0, ovf=0.
  - disp all 4'hF.
  - idx=0, prescaler=0.
  - Therefore an=4'b1110 and digit_bcd=4'hF.
- Decimal write accepted at edge N:
  - busy=1 from N+1 through N+15 (14 SHIFT cycles, then 1 COMMIT).
  - New digits and ovf are visible after edge N+15.
  - busy=0 after edge N+15, so the next write is accepted at edge N+16.
- Hex write accepted at edge N: busy=1 for one cycle only, and new digits are visible after edge N+1.
- Scan: idx holds for exactly SCAN_DIV cycles. The first advance happens SCAN_DIV cycles after reset release.
- COMMIT coinciding with an idx advance: both take effect on the same edge, and the new digit shows the new data.
- Asserting rst_n=0 during SHIFT or COMMIT immediately returns every register to its reset value. Any pending conversion is discarded and the display blanks.

## Test plan
- Reset: hold rst_n=0 → busy=0, ovf=0, an=1110, digit_bcd=F. Release rst_n with SCAN_DIV=4 → an steps 1110, 1101, 1011, 0111, 1110 every 4 cycles, with digit_bcd=F throughout.
- Decimal conversion: write 1234, wr_hex=0, blank_lz=0 → busy high exactly 15 cycles; the scan then shows digit_bcd 4, 3, 2, 1 on an 1110, 1101, 1011, 0111; ovf=0.
- Saturation and overflow:
  - Write 12000 → display 9,9,9,9 and ovf=1.
  - Then write 5 with blank_lz=1 → display 5,F,F,F and ovf=0.
  - Write 0 with blank_lz=1 → display 0,F,F,F.
- Hex mode and dropped writes:
  - Write 16'hA5C3, wr_hex=1 → busy high 1 cycle; digits 3,C,5,A.
  - Write 1234 in decimal mode, then pulse wr_en with 16'h0042 on cycles N+1..N+15 → final display 4,3,2,1.
- Reset mid-conversion: write 8888, assert rst_n=0 at N+7, release → display all F, busy=0. A following write of 42 → display 2,4,0,0.
